// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port unified memory.
// Latency: grant is combinational in the request cycle, read data is registered one cycle later.
// Backpressure: a master that is not granted holds req/a/we/wd. Bursts are capped at MAXBURST while the other master waits.
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-high reset
//   mN_req/we/a/wd        master N request, write flag, byte address, write data
//   mN_gnt                master N access accepted this cycle
//   mN_rd/mN_rvalid       master N registered read data and one-cycle valid pulse
//   mem_we/a/wd, mem_rd   memory port (combinational read data in)
//   busy                  a grant is issued this cycle
module mem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAXBURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_a,
  input  logic [DW-1:0] m0_wd,
  output logic          m0_gnt,
  output logic [DW-1:0] m0_rd,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_a,
  input  logic [DW-1:0] m1_wd,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rd,
  output logic          m1_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic          busy
);

  localparam logic [3:0] MAXB = 4'(MAXBURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_t;

  owner_t     owner, owner_nxt;
  logic [3:0] cnt, cnt_nxt, cnt_inc;
  logic       last, last_nxt;
  logic       win0, win1;

  // The current owner keeps the port until its burst is used up, but only
  // while the other master is actually waiting.
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (!reset) begin
      case (owner)
        IDLE: begin
          if (m0_req && m1_req) begin
            win0 = last;
            win1 = !last;
          end else begin
            win0 = m0_req;
            win1 = m1_req;
          end
        end
        OWN0: begin
          if (m0_req && (cnt < MAXB || !m1_req)) win0 = 1'b1;
          else                                   win1 = m1_req;
        end
        OWN1: begin
          if (m1_req && (cnt < MAXB || !m0_req)) win1 = 1'b1;
          else                                   win0 = m0_req;
        end
        default: ;
      endcase
    end
  end

  assign cnt_inc = (cnt == 4'hF) ? 4'hF : cnt + 4'd1;

  always_comb begin
    owner_nxt = IDLE;
    cnt_nxt   = 4'd0;
    last_nxt  = last;
    if (win0) begin
      owner_nxt = OWN0;
      last_nxt  = 1'b0;
      cnt_nxt   = (owner == OWN0) ? cnt_inc : 4'd1;
    end else if (win1) begin
      owner_nxt = OWN1;
      last_nxt  = 1'b1;
      cnt_nxt   = (owner == OWN1) ? cnt_inc : 4'd1;
    end
  end

  assign m0_gnt = win0;
  assign m1_gnt = win1;
  assign busy   = win0 | win1;

  // Idle port drives zeros so nothing stale reaches the memory.
  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    if (win0) begin
      mem_we = m0_we;
      mem_a  = m0_a;
      mem_wd = m0_wd;
    end else if (win1) begin
      mem_we = m1_we;
      mem_a  = m1_a;
      mem_wd = m1_wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner <= IDLE;
      cnt   <= 4'd0;
      last  <= 1'b1;
    end else begin
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

  // Read data is captured at the edge closing the grant cycle and held
  // until the next granted read for the same master.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rd     <= '0;
      m1_rd     <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      m0_rvalid <= win0 && !m0_we;
      m1_rvalid <= win1 && !m1_we;
      if (win0 && !m0_we) m0_rd <= mem_rd;
      if (win1 && !m1_we) m1_rd <= mem_rd;
    end
  end

endmodule
